fft_power_calc: RTL and testbench
=================================

FFT_POWER_CALC -- requirements
Module: fft_power_calc

Interface
REQ-001 Parameter DW, default 16, signed width of each FFT real/imag sample.
REQ-002 Parameter NFFT, default 1024, FFT frame length; SHALL be a power of two, at least 4.
REQ-003 Parameter HALF, default 1; 1 = forward only bins 0..NFFT/2, 0 = forward all bins.
REQ-004 Parameter SQRT_LAT, default 17, latency in cycles of the downstream square-root stage.
REQ-005 clk  input  1  rising-edge clock.
REQ-006 rst  input  1  reset, asynchronous, active-high.
REQ-007 i_valid  input  1  FFT output sample valid; no backpressure exists.
REQ-008 i_re  input  DW  signed real part.
REQ-009 i_im  input  DW  signed imaginary part.
REQ-010 i_last  input  1  marks the last bin of an FFT frame.
REQ-011 o_valid  output  1  power sample valid; drives the square-root stage input valid.
REQ-012 o_pwr  output  2*DW  unsigned re^2+im^2; drives the square-root stage data input.
REQ-013 o_idx  output  log2(NFFT)  bin index of o_pwr.
REQ-014 o_eop  output  1  last forwarded bin of the frame.
REQ-015 a_valid  output  1  o_valid delayed SQRT_LAT cycles, aligned to the square-root output.
REQ-016 a_idx  output  log2(NFFT)  o_idx delayed SQRT_LAT cycles.
REQ-017 a_eop  output  1  o_eop delayed SQRT_LAT cycles.
REQ-018 frame_err  output  1  sticky framing error flag.
REQ-019 frame_cnt  output  16  count of completed frames, wraps at 65535.

Function
REQ-020 Pipeline SHALL have 3 register stages: input capture, per-component square, sum; latency from i_valid to o_valid is exactly 3 cycles.
REQ-021 Squares SHALL be computed signed, full width. The sum SHALL be unsigned 2*DW bits. Input -2^(DW-1) on both parts yields 2^(2*DW-1) with no overflow.
REQ-022 Bin counter SHALL increment by 1 on each accepted i_valid and wrap from NFFT-1 to 0. Cycles with i_valid=0 are bubbles: counter holds, and the output shows o_valid=0 three cycles later.
REQ-023 o_idx SHALL equal the counter value captured with the sample.
REQ-024 Bin filtering with HALF=1: only bins 0..NFFT/2 SHALL produce o_valid=1; other bins SHALL be dropped, with o_valid=0 and the pipeline slot empty.
REQ-025 o_eop SHALL be 1 on bin NFFT/2 when HALF=1, and on bin NFFT-1 when HALF=0; only ever together with o_valid=1.
REQ-026 i_last at counter NFFT-1: normal end of frame; frame_cnt SHALL increment and the counter SHALL return to 0.
REQ-027 i_last at any counter value other than NFFT-1 SHALL set frame_err, resync the counter to 0 for the next sample, and leave frame_cnt unchanged.
REQ-028 Counter reaching NFFT-1 with i_last=0 SHALL set frame_err; the counter still wraps to 0.
REQ-029 frame_err SHALL stay set until rst.
REQ-030 Delay line: a_valid/a_idx/a_eop SHALL be a SQRT_LAT-deep shift register of o_valid/o_idx/o_eop, advancing every cycle regardless of valid.
REQ-031 When o_valid=0, o_pwr/o_idx/o_eop SHALL be 0.
REQ-032 Back-to-back samples at full rate (i_valid=1 every cycle) SHALL be sustained indefinitely.

Reset
REQ-033 On rst assertion, with no clock required, all outputs, pipeline registers, delay-line entries, bin counter, frame_cnt and frame_err SHALL clear to 0.
REQ-034 rst mid-frame SHALL discard in-flight samples. The first i_valid after rst release is bin 0.

Verification
REQ-035 Single sample, i_re=3, i_im=-4, i_last=0 -> after 3 cycles o_valid=1, o_pwr=25, o_idx=0; a_valid=1 after a further 17 cycles.
REQ-036 i_re=i_im=-32768 -> o_pwr=0x80000000; i_re=32767, i_im=0 -> o_pwr=0x3FFF0001.
REQ-037 NFFT=8, HALF=1, 8 consecutive samples with i_last on the 8th -> o_valid for bins 0..4 only, o_eop on bin 4, frame_cnt=1, frame_err=0.
REQ-038 NFFT=8, i_last on the 5th sample -> frame_err=1, next sample gets o_idx=0, frame_cnt=0; second frame of 8 with i_last correct -> frame_cnt=1, frame_err still 1.
REQ-039 Full-rate frame with random bubbles -> o_idx sequence contiguous 0..NFFT/2, gaps only where inputs gapped, a_* equals o_* shifted 17 cycles.
REQ-040 rst asserted at bin 3 of a frame -> all outputs 0 immediately; after release, next sample -> o_idx=0, no frame_err.

Source files
------------

// File: rtl/fft_power_calc.sv
// fft_power_calc: per-bin |X|^2 of FFT output with bin indexing, frame checks and a delay line for the sqrt stage
module fft_power_calc #(
  parameter int DW = 16,
  parameter int NFFT = 1024,
  parameter int HALF = 1,
  parameter int SQRT_LAT = 17,
  localparam int IW = $clog2(NFFT)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_valid,
  input  logic signed [DW-1:0] i_re,
  input  logic signed [DW-1:0] i_im,
  input  logic                 i_last,
  output logic                 o_valid,
  output logic [2*DW-1:0]      o_pwr,
  output logic [IW-1:0]        o_idx,
  output logic                 o_eop,
  output logic                 a_valid,
  output logic [IW-1:0]        a_idx,
  output logic                 a_eop,
  output logic                 frame_err,
  output logic [15:0]          frame_cnt
);
  localparam logic [IW-1:0] LAST_BIN = IW'(NFFT - 1);
  localparam logic [IW-1:0] HALF_BIN = IW'(NFFT / 2);
  localparam logic [IW-1:0] EOP_BIN = (HALF != 0) ? HALF_BIN : LAST_BIN;
  logic [IW-1:0] cnt, cnt_nxt;
  logic at_last, keep, take;
  logic s1_v, s1_eop, s2_v, s2_eop;
  logic signed [DW-1:0] s1_re, s1_im;
  logic signed [2*DW-1:0] sq_re, sq_im;
  logic [IW-1:0] s1_idx, s2_idx;
  logic [SQRT_LAT-1:0] dl_v, dl_e;
  logic [IW-1:0] dl_i [SQRT_LAT];
  always_comb begin
    at_last = cnt == LAST_BIN;
    keep = (HALF == 0) || (cnt <= HALF_BIN);
    take = i_valid && keep;
    cnt_nxt = !i_valid ? cnt : (i_last || at_last) ? '0 : cnt + 1'b1;
  end
  // i_last and the counter's last bin must coincide; any disagreement is a framing error
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
      frame_err <= 1'b0;
      frame_cnt <= '0;
    end else begin
      cnt <= cnt_nxt;
      if (i_valid && (i_last != at_last)) frame_err <= 1'b1;
      if (i_valid && i_last && at_last) frame_cnt <= frame_cnt + 1'b1;
    end
  end
  // dropped or empty slots carry zeros so outputs read 0 whenever o_valid is low
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_v <= 1'b0;
      s1_re <= '0;
      s1_im <= '0;
      s1_idx <= '0;
      s1_eop <= 1'b0;
      s2_v <= 1'b0;
      sq_re <= '0;
      sq_im <= '0;
      s2_idx <= '0;
      s2_eop <= 1'b0;
      o_valid <= 1'b0;
      o_pwr <= '0;
      o_idx <= '0;
      o_eop <= 1'b0;
    end else begin
      s1_v <= take;
      s1_re <= take ? i_re : '0;
      s1_im <= take ? i_im : '0;
      s1_idx <= take ? cnt : '0;
      s1_eop <= take && (cnt == EOP_BIN);
      s2_v <= s1_v;
      sq_re <= s1_re * s1_re;
      sq_im <= s1_im * s1_im;
      s2_idx <= s1_idx;
      s2_eop <= s1_eop;
      o_valid <= s2_v;
      o_pwr <= sq_re + sq_im;
      o_idx <= s2_idx;
      o_eop <= s2_eop;
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dl_v <= '0;
      dl_e <= '0;
      for (int i = 0; i < SQRT_LAT; i++) dl_i[i] <= '0;
    end else begin
      dl_v[0] <= o_valid;
      dl_e[0] <= o_eop;
      dl_i[0] <= o_idx;
      for (int i = 1; i < SQRT_LAT; i++) begin
        dl_v[i] <= dl_v[i-1];
        dl_e[i] <= dl_e[i-1];
        dl_i[i] <= dl_i[i-1];
      end
    end
  end
  assign a_valid = dl_v[SQRT_LAT-1];
  assign a_eop = dl_e[SQRT_LAT-1];
  assign a_idx = dl_i[SQRT_LAT-1];
endmodule

// File: tb/tb_fft_power_calc.sv
// tb_fft_power_calc: directed checks of fft_power_calc with NFFT=8, HALF=1, SQRT_LAT=17
module tb_fft_power_calc;
  localparam int DW = 16;
  localparam int NFFT = 8;
  localparam int IW = 3;
  logic clk = 1'b0, rst = 1'b1;
  logic i_valid = 1'b0, i_last = 1'b0;
  logic signed [DW-1:0] i_re = '0, i_im = '0;
  logic o_valid, o_eop, a_valid, a_eop, frame_err;
  logic [2*DW-1:0] o_pwr;
  logic [IW-1:0] o_idx, a_idx;
  logic [15:0] frame_cnt;
  int checks = 0, errors = 0;
  logic ev [36];
  logic ee [36];
  logic [IW-1:0] ei [36];

  fft_power_calc #(.DW(DW), .NFFT(NFFT), .HALF(1), .SQRT_LAT(17)) dut (
    .clk(clk), .rst(rst), .i_valid(i_valid), .i_re(i_re), .i_im(i_im), .i_last(i_last),
    .o_valid(o_valid), .o_pwr(o_pwr), .o_idx(o_idx), .o_eop(o_eop),
    .a_valid(a_valid), .a_idx(a_idx), .a_eop(a_eop),
    .frame_err(frame_err), .frame_cnt(frame_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input logic v, input int re, input int im, input logic last);
    @(negedge clk);
    i_valid = v;
    i_re = 16'(re);
    i_im = 16'(im);
    i_last = last;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    i_valid = 1'b0;
    i_last = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    logic [11:0] pat;
    logic [IW-1:0] cnt;
    int nv;
    #2;
    chk("rst_o_valid", o_valid, 0);
    chk("rst_a_valid", a_valid, 0);
    chk("rst_frame_err", frame_err, 0);
    chk("rst_frame_cnt", frame_cnt, 0);
    do_reset();
    // single sample 3-4j
    tick(1, 3, -4, 0);
    repeat (3) tick(0, 0, 0, 0);
    chk("single_valid", o_valid, 1);
    chk("single_pwr", o_pwr, 25);
    chk("single_idx", o_idx, 0);
    tick(0, 0, 0, 0);
    chk("single_bubble_valid", o_valid, 0);
    chk("single_bubble_pwr", o_pwr, 0);
    repeat (15) tick(0, 0, 0, 0);
    chk("single_a_early", a_valid, 0);
    tick(0, 0, 0, 0);
    chk("single_a_valid", a_valid, 1);
    chk("single_a_idx", a_idx, 0);
    // extremes
    tick(1, -32768, -32768, 0);
    tick(1, 32767, 0, 0);
    tick(0, 0, 0, 0);
    tick(0, 0, 0, 0);
    chk("min_pwr", o_pwr, 64'h8000_0000);
    chk("min_idx", o_idx, 1);
    tick(0, 0, 0, 0);
    chk("max_pwr", o_pwr, 64'h3FFF_0001);
    chk("max_idx", o_idx, 2);
    // clean frame, half spectrum forwarded
    do_reset();
    for (int t = 0; t < 11; t++) begin
      tick(t < 8, t + 1, 0, t == 7);
      if (t >= 3) begin
        chk($sformatf("frame_valid_b%0d", t - 3), o_valid, (t - 3) <= 4);
        chk($sformatf("frame_idx_b%0d", t - 3), o_idx, ((t - 3) <= 4) ? 64'(t - 3) : 0);
        chk($sformatf("frame_eop_b%0d", t - 3), o_eop, (t - 3) == 4);
        chk($sformatf("frame_pwr_b%0d", t - 3), o_pwr, ((t - 3) <= 4) ? 64'((t - 2) * (t - 2)) : 0);
      end
    end
    chk("frame_cnt_1", frame_cnt, 1);
    chk("frame_err_0", frame_err, 0);
    // early i_last, then a correct frame
    do_reset();
    for (int b = 0; b < 5; b++) tick(1, 1, 1, b == 4);
    for (int b = 0; b < 8; b++) begin
      tick(1, b + 1, 0, b == 7);
      if (b == 0) begin
        chk("early_err", frame_err, 1);
        chk("early_cnt", frame_cnt, 0);
      end
      if (b == 3) begin
        chk("resync_valid", o_valid, 1);
        chk("resync_idx", o_idx, 0);
      end
    end
    repeat (3) tick(0, 0, 0, 0);
    chk("recover_cnt", frame_cnt, 1);
    chk("recover_err_sticky", frame_err, 1);
    // frame with bubbles, o_* and a_* against a bin model
    do_reset();
    pat = 12'b1101_1100_1011;
    cnt = '0;
    nv = 0;
    for (int t = 0; t < 36; t++) begin
      logic v;
      v = (t < 12) ? pat[t] : 1'b0;
      if (v) nv++;
      tick(v, 1, 1, v && nv == 8);
      ev[t] = v && cnt <= 4;
      ei[t] = ev[t] ? cnt : '0;
      ee[t] = ev[t] && cnt == 4;
      if (v) cnt = cnt + 1'b1;
      if (t >= 3) begin
        chk($sformatf("gap_o_valid_t%0d", t), o_valid, ev[t-3]);
        chk($sformatf("gap_o_idx_t%0d", t), o_idx, ei[t-3]);
        chk($sformatf("gap_o_eop_t%0d", t), o_eop, ee[t-3]);
        chk($sformatf("gap_o_pwr_t%0d", t), o_pwr, ev[t-3] ? 2 : 0);
      end
      if (t >= 20) begin
        chk($sformatf("gap_a_valid_t%0d", t), a_valid, ev[t-20]);
        chk($sformatf("gap_a_idx_t%0d", t), a_idx, ei[t-20]);
        chk($sformatf("gap_a_eop_t%0d", t), a_eop, ee[t-20]);
      end
    end
    chk("gap_frame_cnt", frame_cnt, 1);
    chk("gap_frame_err", frame_err, 0);
    // reset mid-frame
    do_reset();
    for (int b = 0; b < 4; b++) tick(1, b + 1, 1, 0);
    chk("midrst_pre_valid", o_valid, 1);
    #2;
    rst = 1'b1;
    i_valid = 1'b0;
    #1;
    chk("midrst_o_valid", o_valid, 0);
    chk("midrst_o_pwr", o_pwr, 0);
    chk("midrst_a_valid", a_valid, 0);
    @(negedge clk);
    rst = 1'b0;
    tick(1, 2, 2, 0);
    repeat (3) tick(0, 0, 0, 0);
    chk("midrst_post_valid", o_valid, 1);
    chk("midrst_post_idx", o_idx, 0);
    chk("midrst_post_pwr", o_pwr, 8);
    chk("midrst_post_err", frame_err, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
